// File: rtl/mjpg_pkg.sv
// Shared definitions for the MJPG frame packer: FSM states,
// JPEG marker bytes and FIFO entry layout.
package mjpg_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HUNT_FF,
    ST_FRAME,
    ST_FRAME_FF,
    ST_FLUSH,
    ST_DROP,
    ST_DROP_FF
  } state_e;

  localparam logic [7:0] MARK_FF  = 8'hFF;
  localparam logic [7:0] MARK_SOI = 8'hD8;
  localparam logic [7:0] MARK_EOI = 8'hD9;

  localparam int ENT_W    = 10;
  localparam int ENT_DMSB = 7;
  localparam int ENT_LAST = 8;
  localparam int ENT_ERR  = 9;

  function automatic logic [ENT_W-1:0] pack_ent(
    input logic       err,
    input logic       last,
    input logic [7:0] data
  );
    return {err, last, data};
  endfunction

endpackage

// File: rtl/jpeg_byte_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Head entry is read combinationally, so a write is visible right after its edge.
module jpeg_byte_fifo
  import mjpg_pkg::*;
#(
  parameter int AW = 11,
  parameter int W  = ENT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && (cnt_q != FULL);
    do_pop  = pop && (cnt_q != '0);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; validity comes from cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/mjpg_frame_packer.sv
// Frames the raw JPEG byte strobe into SOI..EOI packets on a
// valid/ready stream, truncating with an error flag on overflow.
module mjpg_frame_packer
  import mjpg_pkg::*;
#(
  parameter int FIFO_AW = 11,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jvalid,
  input  logic [7:0]       jpeg,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             m_err,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_bytes,
  output logic             frame_err,
  output logic [15:0]      drop_count
);

  localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] NEAR = {1'b0, {FIFO_AW{1'b1}}};

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fb_q, fb_d;
  logic             ferr_q, ferr_d;
  logic             fdone_q, fdone_d;
  logic [15:0]      drops_q, drops_d;

  logic             push, plast, perr, soi;
  logic [7:0]       pdata;
  logic [CNT_W-1:0] cnt_n;
  logic [ENT_W-1:0] rdata;
  logic             fifo_valid;
  logic [FIFO_AW:0] fifo_count;

  jpeg_byte_fifo #(
    .AW (FIFO_AW),
    .W  (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (pack_ent(perr, plast, pdata)),
    .pop   (m_ready && fifo_valid),
    .rdata (rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    push    = 1'b0;
    pdata   = hold_q;
    plast   = 1'b0;
    perr    = 1'b0;
    soi     = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (jvalid && jpeg == MARK_FF) state_d = ST_HUNT_FF;
      end
      ST_HUNT_FF: begin
        if (jvalid) begin
          if (jpeg == MARK_SOI && fifo_count != FULL) begin
            push    = 1'b1;
            pdata   = MARK_FF;
            soi     = 1'b1;
            hold_d  = jpeg;
            state_d = ST_FRAME;
          end else if (jpeg != MARK_FF) begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_FRAME: begin
        if (jvalid) begin
          push   = 1'b1;
          hold_d = jpeg;
          if (jpeg == MARK_FF) state_d = ST_FRAME_FF;
        end
      end
      ST_FRAME_FF: begin
        if (jvalid) begin
          push = 1'b1;
          if (jpeg == MARK_SOI) begin
            // A fresh SOI mid-frame aborts; that SOI is consumed.
            plast   = 1'b1;
            perr    = 1'b1;
            state_d = ST_HUNT;
          end else begin
            hold_d = jpeg;
            if (jpeg == MARK_EOI) state_d = ST_FLUSH;
            else if (jpeg != MARK_FF) state_d = ST_FRAME;
          end
        end
      end
      ST_FLUSH: begin
        push    = 1'b1;
        pdata   = MARK_EOI;
        plast   = 1'b1;
        state_d = (jvalid && jpeg == MARK_FF) ? ST_HUNT_FF : ST_HUNT;
      end
      ST_DROP: begin
        if (jvalid && jpeg == MARK_FF) state_d = ST_DROP_FF;
      end
      ST_DROP_FF: begin
        if (jvalid) begin
          if (jpeg == MARK_EOI) state_d = ST_HUNT;
          else if (jpeg != MARK_FF) state_d = ST_DROP;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Last free slot only ever takes a packet terminator.
    if (push && !plast && fifo_count == NEAR) begin
      plast   = 1'b1;
      perr    = 1'b1;
      hold_d  = '0;
      state_d = ST_DROP;
    end

    if (soi) cnt_n = CNT_W'(1);
    else if (cnt_q == '1) cnt_n = cnt_q;
    else cnt_n = cnt_q + CNT_W'(1);

    cnt_d   = push ? cnt_n : cnt_q;
    fdone_d = push && plast;
    fb_d    = fdone_d ? cnt_n : fb_q;
    ferr_d  = fdone_d ? perr : ferr_q;
    drops_d = drops_q;
    if (fdone_d && perr && drops_q != 16'hFFFF) begin
      drops_d = drops_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      hold_q  <= '0;
      cnt_q   <= '0;
      fb_q    <= '0;
      ferr_q  <= 1'b0;
      fdone_q <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      fb_q    <= fb_d;
      ferr_q  <= ferr_d;
      fdone_q <= fdone_d;
      drops_q <= drops_d;
    end
  end

  assign m_valid     = fifo_valid;
  assign m_data      = fifo_valid ? rdata[ENT_DMSB:0] : 8'h00;
  assign m_last      = fifo_valid && rdata[ENT_LAST];
  assign m_err       = fifo_valid && rdata[ENT_ERR];
  assign frame_done  = fdone_q;
  assign frame_bytes = fb_q;
  assign frame_err   = ferr_q;
  assign drop_count  = drops_q;

endmodule

// File: tb/tb_mjpg_frame_packer.sv
// Directed bench for mjpg_frame_packer with a 16-entry FIFO.
// Expected packets are written out by hand per step.
module tb_mjpg_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jvalid = 1'b0;
  logic [7:0]  jpeg = 8'h00;
  logic        m_ready = 1'b0;
  logic        m_valid, m_last, m_err;
  logic [7:0]  m_data;
  logic        frame_done, frame_err;
  logic [23:0] frame_bytes;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  mjpg_frame_packer #(
    .FIFO_AW (4),
    .CNT_W   (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jvalid      (jvalid),
    .jpeg        (jpeg),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_err       (m_err),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes),
    .frame_err   (frame_err),
    .drop_count  (drop_count)
  );

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0]  stim[$];
  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  logic [24:0] fd_exp[$];
  logic [24:0] fd_q[$];

  logic        rnd_mode = 1'b0;
  int          nrdy = 0;
  logic        stall_v = 1'b0;
  logic [9:0]  stall_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_v)
        chk("stall_hold", {21'd0, m_valid, m_err, m_last, m_data},
            {21'd0, 1'b1, stall_d});
      if (m_valid && m_ready) got_q.push_back({m_err, m_last, m_data});
      stall_v = m_valid && !m_ready;
      stall_d = {m_err, m_last, m_data};
      if (frame_done) fd_q.push_back({frame_err, frame_bytes});
    end else begin
      stall_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      if (nrdy >= 2) m_ready = 1'b1;
      else m_ready = 1'($urandom_range(0, 1));
      nrdy = m_ready ? 0 : nrdy + 1;
    end
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim.size(); i++) begin
      jvalid = 1'b1;
      jpeg   = stim[i];
      tick();
    end
    jvalid = 1'b0;
    jpeg   = 8'h00;
  endtask

  task automatic drain_check(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (6) tick();
    chk($sformatf("%s_nbytes", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got_q.size()) ? {22'd0, got_q[i]} : 32'hDEAD,
          {22'd0, exp_q[i]});
    chk($sformatf("%s_nframes", tag), fd_q.size(), fd_exp.size());
    for (int i = 0; i < fd_exp.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i),
          (i < fd_q.size()) ? {7'd0, fd_q[i]} : 32'hDEAD,
          {7'd0, fd_exp[i]});
    got_q.delete();
    exp_q.delete();
    fd_q.delete();
    fd_exp.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_bytes", frame_bytes, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    tick();

    // Basic frame with leading garbage and byte stuffing
    m_ready = 1'b1;
    stim = '{8'h12, 8'h34, 8'hFF, 8'hD8, 8'h01, 8'h02,
             8'hFF, 8'h00, 8'hFF, 8'hD9};
    exp_q = '{10'h0FF, 10'h0D8, 10'h001, 10'h002,
              10'h0FF, 10'h000, 10'h0FF, 10'h1D9};
    fd_exp = '{{1'b0, 24'd8}};
    send_stim();
    drain_check("t1");
    chk("t1_drops", drop_count, 0);

    // Fill bytes before SOI dropped, inside frame kept
    stim = '{8'hFF, 8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hFF, 8'hD9};
    exp_q = '{10'h0FF, 10'h0D8, 10'h0AA, 10'h0FF, 10'h0FF, 10'h1D9};
    fd_exp = '{{1'b0, 24'd6}};
    send_stim();
    drain_check("t2");

    // Overflow of a 16-entry FIFO with the sink stalled
    m_ready = 1'b0;
    stim = '{8'hFF, 8'hD8};
    for (int i = 0; i < 16; i++) stim.push_back(8'h10 + 8'(i));
    stim.push_back(8'hFF);
    stim.push_back(8'hD9);
    exp_q = '{10'h0FF, 10'h0D8};
    for (int i = 0; i < 13; i++) exp_q.push_back(10'h010 + 10'(i));
    exp_q.push_back(10'h31D);
    fd_exp = '{{1'b1, 24'd16}};
    send_stim();
    repeat (3) tick();
    chk("t3_m_valid", m_valid, 1);
    chk("t3_head", m_data, 8'hFF);
    chk("t3_fbytes", frame_bytes, 16);
    chk("t3_ferr", frame_err, 1);
    chk("t3_drops", drop_count, 1);
    m_ready = 1'b1;
    drain_check("t3");
    stim = '{8'hFF, 8'hD8, 8'h11, 8'h22, 8'hFF, 8'hD9};
    exp_q = '{10'h0FF, 10'h0D8, 10'h011, 10'h022, 10'h0FF, 10'h1D9};
    fd_exp = '{{1'b0, 24'd6}};
    send_stim();
    drain_check("t3b");

    // SOI inside a frame aborts it; resync needs a new SOI
    stim = '{8'hFF, 8'hD8, 8'h01, 8'hFF, 8'hD8, 8'h02, 8'hFF, 8'hD9};
    exp_q = '{10'h0FF, 10'h0D8, 10'h001, 10'h3FF};
    fd_exp = '{{1'b1, 24'd4}};
    send_stim();
    drain_check("t4");
    chk("t4_drops", drop_count, 2);

    // Three back-to-back frames with a randomly stalling sink
    rnd_mode = 1'b1;
    stim = '{8'hFF, 8'hD8, 8'hA1, 8'hA2, 8'hFF, 8'hD9,
             8'hFF, 8'hD8, 8'hB1, 8'hFF, 8'h00, 8'hFF, 8'hD9,
             8'hFF, 8'hD8, 8'hC1, 8'hC2, 8'hC3, 8'hFF, 8'hD9};
    exp_q = '{10'h0FF, 10'h0D8, 10'h0A1, 10'h0A2, 10'h0FF, 10'h1D9,
              10'h0FF, 10'h0D8, 10'h0B1, 10'h0FF, 10'h000, 10'h0FF,
              10'h1D9,
              10'h0FF, 10'h0D8, 10'h0C1, 10'h0C2, 10'h0C3, 10'h0FF,
              10'h1D9};
    fd_exp = '{{1'b0, 24'd6}, {1'b0, 24'd7}, {1'b0, 24'd7}};
    send_stim();
    drain_check("t5");
    rnd_mode = 1'b0;
    m_ready = 1'b1;
    tick();

    // Asynchronous reset in the middle of a frame
    m_ready = 1'b0;
    stim = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03};
    send_stim();
    tick();
    chk("t6_pre_valid", m_valid, 1);
    #3;
    rst_n = 1'b0;
    #2;
    chk("t6_async_valid", m_valid, 0);
    chk("t6_async_drops", drop_count, 0);
    got_q.delete();
    fd_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    stim = '{8'h04, 8'h05, 8'hFF, 8'hD9};
    send_stim();
    repeat (3) tick();
    chk("t6_tail_valid", m_valid, 0);
    drain_check("t6_tail");
    stim = '{8'hFF, 8'hD8, 8'h77, 8'hFF, 8'hD9};
    exp_q = '{10'h0FF, 10'h0D8, 10'h077, 10'h0FF, 10'h1D9};
    fd_exp = '{{1'b0, 24'd5}};
    send_stim();
    drain_check("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
